// File: rtl/jt49_vol_sched.sv
// jt49_vol_sched: shares one external 5-bit log-to-linear table among the
// three PSG channels. A sample request latches the gated levels. The block
// then looks up A, B and C on successive cen ticks and sums them. It
// publishes all four results together with a one-clk valid pulse.
// Optional: define JT49_VOL_SCHED_OVR_EN to build the sticky overrun flag
// (request seen while busy); otherwise overrun is tied low.
module jt49_vol_sched #(
    parameter int MIXW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            sample_req,
    input  logic [4:0]      vol_a,
    input  logic [4:0]      vol_b,
    input  logic [4:0]      vol_c,
    input  logic            en_a,
    input  logic            en_b,
    input  logic            en_c,
    output logic [4:0]      exp_din,
    input  logic [7:0]      exp_dout,
    output logic [7:0]      dout_a,
    output logic [7:0]      dout_b,
    output logic [7:0]      dout_c,
    output logic [MIXW-1:0] mix,
    output logic            valid,
    output logic            busy,
    output logic            overrun,
    input  logic            ovr_clr
);

    typedef enum logic [2:0] {IDLE, LK_A, LK_B, LK_C, DONE} state_t;

    state_t     state_q, state_d;
    logic [4:0] lvl_a_q, lvl_a_d, lvl_b_q, lvl_b_d, lvl_c_q, lvl_c_d;
    logic [7:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d, tmp_c_q, tmp_c_d;
    logic [9:0] acc_q, acc_d;
    logic [4:0] exp_din_q, exp_din_d;
    logic [7:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d, dout_c_q, dout_c_d;
    logic [9:0] mix_q, mix_d;
    logic       valid_d, valid_q;

    // Next-state and datapath: every register holds unless cen, except valid,
    // which drops on the following clk so the pulse is never stretched.
    always_comb begin
        state_d   = state_q;
        lvl_a_d   = lvl_a_q;
        lvl_b_d   = lvl_b_q;
        lvl_c_d   = lvl_c_q;
        tmp_a_d   = tmp_a_q;
        tmp_b_d   = tmp_b_q;
        tmp_c_d   = tmp_c_q;
        acc_d     = acc_q;
        exp_din_d = exp_din_q;
        dout_a_d  = dout_a_q;
        dout_b_d  = dout_b_q;
        dout_c_d  = dout_c_q;
        mix_d     = mix_q;
        valid_d   = 1'b0;
        if (cen) begin
            case (state_q)
                IDLE: begin
                    if (sample_req) begin
                        lvl_a_d   = en_a ? vol_a : 5'd0;
                        lvl_b_d   = en_b ? vol_b : 5'd0;
                        lvl_c_d   = en_c ? vol_c : 5'd0;
                        acc_d     = 10'd0;
                        // the index for A is presented as soon as LK_A begins
                        exp_din_d = en_a ? vol_a : 5'd0;
                        state_d   = LK_A;
                    end
                end
                LK_A: begin
                    tmp_a_d   = exp_dout;
                    acc_d     = acc_q + {2'b00, exp_dout};
                    exp_din_d = lvl_b_q;
                    state_d   = LK_B;
                end
                LK_B: begin
                    tmp_b_d   = exp_dout;
                    acc_d     = acc_q + {2'b00, exp_dout};
                    exp_din_d = lvl_c_q;
                    state_d   = LK_C;
                end
                LK_C: begin
                    tmp_c_d   = exp_dout;
                    acc_d     = acc_q + {2'b00, exp_dout};
                    exp_din_d = 5'd0;
                    state_d   = DONE;
                end
                DONE: begin
                    dout_a_d = tmp_a_q;
                    dout_b_d = tmp_b_q;
                    dout_c_d = tmp_c_q;
                    mix_d    = acc_q;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lvl_a_q   <= '0;
            lvl_b_q   <= '0;
            lvl_c_q   <= '0;
            tmp_a_q   <= '0;
            tmp_b_q   <= '0;
            tmp_c_q   <= '0;
            acc_q     <= '0;
            exp_din_q <= '0;
            dout_a_q  <= '0;
            dout_b_q  <= '0;
            dout_c_q  <= '0;
            mix_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lvl_a_q   <= lvl_a_d;
            lvl_b_q   <= lvl_b_d;
            lvl_c_q   <= lvl_c_d;
            tmp_a_q   <= tmp_a_d;
            tmp_b_q   <= tmp_b_d;
            tmp_c_q   <= tmp_c_d;
            acc_q     <= acc_d;
            exp_din_q <= exp_din_d;
            dout_a_q  <= dout_a_d;
            dout_b_q  <= dout_b_d;
            dout_c_q  <= dout_c_d;
            mix_q     <= mix_d;
            valid_q   <= valid_d;
        end
    end

    assign exp_din = exp_din_q;
    assign dout_a  = dout_a_q;
    assign dout_b  = dout_b_q;
    assign dout_c  = dout_c_q;
    assign mix     = MIXW'(mix_q);
    assign valid   = valid_q;
    assign busy    = (state_q != IDLE);

`ifdef JT49_VOL_SCHED_OVR_EN
    logic ovr_q, ovr_d;

    // Sticky overrun: a request while busy sets it, ovr_clr clears it, set wins
    always_comb begin
        ovr_d = ovr_q;
        if (ovr_clr) ovr_d = 1'b0;
        if (cen && sample_req && (state_q != IDLE)) ovr_d = 1'b1;
    end

    // Overrun register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovr_q <= 1'b0;
        else     ovr_q <= ovr_d;
    end

    assign overrun = ovr_q;
`else
    logic ovr_clr_unused;
    assign ovr_clr_unused = ovr_clr;
    assign overrun        = 1'b0;
`endif

endmodule
